// File: rtl/boot_loader.sv
// Streaming program loader: assembles little-endian words from a byte stream,
// writes them to instruction memory, and enables the core once the XOR checksum matches.
module boot_loader #(
    parameter int DEPTH = 64
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [7:0]  RxData,
    input  logic        RxValid,
    output logic        RxReady,
    output logic        ImemWE,
    output logic [31:0] ImemAddr,
    output logic [31:0] ImemWD,
    output logic        Enable,
    output logic        Error,
    output logic [31:0] WordCount
);

    localparam int IDX_W = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_HDR,
        S_DATA,
        S_CHK,
        S_RUN,
        S_ERR
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         bcnt_q, bcnt_d;
    logic [23:0]        shift_q, shift_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        csum_q, csum_d;
    logic               rdy_q, rdy_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wd_q, wd_d;
    logic               en_q, en_d;
    logic               err_q, err_d;
    logic [31:0]        wc_q, wc_d;

    logic               xfer;
    logic               word_done;
    logic [31:0]        word;
    logic [IDX_W-1:0]   idx_inc;
    logic               last_data;
    logic               hdr_bad;

    // The fourth byte completes the word combinationally with the three held bytes.
    assign xfer      = RxValid && rdy_q;
    assign word_done = xfer && (bcnt_q == 2'd3);
    assign word      = {RxData, shift_q};
    assign idx_inc   = idx_q + IDX_W'(1);
    assign last_data = ({{(32-IDX_W){1'b0}}, idx_inc} == wc_q);
    assign hdr_bad   = (word == 32'd0) || (word > 32'(DEPTH));

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= S_HDR;
            bcnt_q  <= 2'd0;
            shift_q <= 24'd0;
            idx_q   <= '0;
            csum_q  <= 32'd0;
            rdy_q   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wd_q    <= 32'd0;
            en_q    <= 1'b0;
            err_q   <= 1'b0;
            wc_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            rdy_q   <= rdy_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            en_q    <= en_d;
            err_q   <= err_d;
            wc_q    <= wc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HDR: begin
                if (word_done) begin
                    state_d = hdr_bad ? S_ERR : S_DATA;
                end
            end
            S_DATA: begin
                if (word_done && last_data) begin
                    state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (word_done) begin
                    state_d = (word == csum_q) ? S_RUN : S_ERR;
                end
            end
            S_RUN:   state_d = S_RUN;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase
    end

    always_comb begin
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wd_d    = wd_q;
        wc_d    = wc_q;

        if (xfer) begin
            bcnt_d  = bcnt_q + 2'd1;
            shift_d = {RxData, shift_q[23:8]};
        end

        if (word_done) begin
            case (state_q)
                S_HDR: begin
                    wc_d = word;
                    if (!hdr_bad) begin
                        idx_d  = '0;
                        csum_d = 32'd0;
                    end
                end
                S_DATA: begin
                    we_d   = 1'b1;
                    addr_d = {{(30-IDX_W){1'b0}}, idx_q, 2'b00};
                    wd_d   = word;
                    csum_d = csum_q ^ word;
                    idx_d  = idx_inc;
                end
                default: ;
            endcase
        end

        // Status outputs are registered from the next state so they line up with it.
        rdy_d = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CHK);
        en_d  = (state_d == S_RUN);
        err_d = (state_d == S_ERR);
    end

    assign RxReady   = rdy_q;
    assign ImemWE    = we_q;
    assign ImemAddr  = addr_q;
    assign ImemWD    = wd_q;
    assign Enable    = en_q;
    assign Error     = err_q;
    assign WordCount = wc_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: table of per-word vectors plus hand-written multi-cycle sequences.
module tb_boot_loader;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [7:0]  RxData;
    logic        RxValid;
    logic        RxReady;
    logic        ImemWE;
    logic [31:0] ImemAddr;
    logic [31:0] ImemWD;
    logic        Enable;
    logic        Error;
    logic [31:0] WordCount;

    int n_checks = 0;
    int n_errors = 0;

    int          wr_cnt = 0;
    logic [31:0] last_addr = 32'd0;
    logic [31:0] last_wd = 32'd0;

    boot_loader #(.DEPTH(64)) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .RxData   (RxData),
        .RxValid  (RxValid),
        .RxReady  (RxReady),
        .ImemWE   (ImemWE),
        .ImemAddr (ImemAddr),
        .ImemWD   (ImemWD),
        .Enable   (Enable),
        .Error    (Error),
        .WordCount(WordCount)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (ImemWE === 1'b1) begin
            wr_cnt    = wr_cnt + 1;
            last_addr = ImemAddr;
            last_wd   = ImemWD;
        end
    end

    typedef struct {
        logic        rst_before;
        logic [31:0] word;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        en;
        logic        err;
        logic        rdy;
        logic [31:0] wc;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_cycle(input bit check_we);
        RxValid = 1'b0;
        RxData  = 8'($urandom);
        @(posedge CLK);
        #1;
        if (check_we) chk("we_idle", 32'(ImemWE), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        RxData  = b;
        RxValid = 1'b1;
        @(posedge CLK);
        #1;
        RxValid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < gap; g++) idle_cycle(1'b1);
            send_byte(w[8*k +: 8]);
            if (gap > 0 && k < 3) chk("we_midword", 32'(ImemWE), 32'd0);
        end
    endtask

    task automatic apply_reset(input logic v);
        Reset   = 1'b1;
        RxValid = v;
        RxData  = 8'hAA;
        @(posedge CLK);
        #1;
        Reset   = 1'b0;
        RxValid = 1'b0;
    endtask

    task automatic check_reset_vals();
        chk("rst_rdy",  32'(RxReady), 32'd1);
        chk("rst_we",   32'(ImemWE),  32'd0);
        chk("rst_addr", ImemAddr,     32'd0);
        chk("rst_wd",   ImemWD,       32'd0);
        chk("rst_en",   32'(Enable),  32'd0);
        chk("rst_err",  32'(Error),   32'd0);
        chk("rst_wc",   WordCount,    32'd0);
    endtask

    task automatic run_vectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (vecs[i].rst_before) apply_reset(1'b0);
            send_word(vecs[i].word, 0);
            chk($sformatf("v%0d_we", i), 32'(ImemWE), 32'(vecs[i].we));
            if (vecs[i].we) begin
                chk($sformatf("v%0d_addr", i), ImemAddr, vecs[i].addr);
                chk($sformatf("v%0d_wd", i), ImemWD, vecs[i].wd);
            end
            chk($sformatf("v%0d_en", i),  32'(Enable),  32'(vecs[i].en));
            chk($sformatf("v%0d_err", i), 32'(Error),   32'(vecs[i].err));
            chk($sformatf("v%0d_rdy", i), 32'(RxReady), 32'(vecs[i].rdy));
            chk($sformatf("v%0d_wc", i),  WordCount,    vecs[i].wc);
        end
    endtask

    task automatic good_stream(input int gap);
        send_word(32'd2, gap);
        send_word(32'hE3A01005, gap);
        chk("s_we0",   32'(ImemWE), 32'd1);
        chk("s_addr0", ImemAddr, 32'h0);
        chk("s_wd0",   ImemWD, 32'hE3A01005);
        send_word(32'hE2812003, gap);
        chk("s_we1",   32'(ImemWE), 32'd1);
        chk("s_addr1", ImemAddr, 32'h4);
        chk("s_wd1",   ImemWD, 32'hE2812003);
        send_word(32'h01213006, gap);
        chk("s_en",  32'(Enable),  32'd1);
        chk("s_err", 32'(Error),   32'd0);
        chk("s_rdy", 32'(RxReady), 32'd0);
    endtask

    initial begin
        int base;
        vecs[0] = '{1'b1, 32'd2,          1'b0, 32'h0, 32'h0,          1'b0, 1'b0, 1'b1, 32'd2};
        vecs[1] = '{1'b0, 32'hE3A01005,   1'b1, 32'h0, 32'hE3A01005,   1'b0, 1'b0, 1'b1, 32'd2};
        vecs[2] = '{1'b0, 32'hE2812003,   1'b1, 32'h4, 32'hE2812003,   1'b0, 1'b0, 1'b1, 32'd2};
        vecs[3] = '{1'b0, 32'h01213006,   1'b0, 32'h0, 32'h0,          1'b1, 1'b0, 1'b0, 32'd2};
        vecs[4] = '{1'b1, 32'd2,          1'b0, 32'h0, 32'h0,          1'b0, 1'b0, 1'b1, 32'd2};
        vecs[5] = '{1'b0, 32'hE3A01005,   1'b1, 32'h0, 32'hE3A01005,   1'b0, 1'b0, 1'b1, 32'd2};
        vecs[6] = '{1'b0, 32'hE2812003,   1'b1, 32'h4, 32'hE2812003,   1'b0, 1'b0, 1'b1, 32'd2};
        vecs[7] = '{1'b0, 32'h01213007,   1'b0, 32'h0, 32'h0,          1'b0, 1'b1, 1'b0, 32'd2};
        vecs[8] = '{1'b1, 32'd0,          1'b0, 32'h0, 32'h0,          1'b0, 1'b1, 1'b0, 32'd0};
        vecs[9] = '{1'b1, 32'd65,         1'b0, 32'h0, 32'h0,          1'b0, 1'b1, 1'b0, 32'd65};

        Reset   = 1'b1;
        RxValid = 1'b0;
        RxData  = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        Reset = 1'b0;
        check_reset_vals();

        // Good load, then checksum mismatch.
        base = wr_cnt;
        run_vectors(0, 3);
        chk("a_writes", 32'(wr_cnt - base), 32'd2);
        base = wr_cnt;
        run_vectors(4, 7);
        chk("b_writes", 32'(wr_cnt - base), 32'd2);

        // Error must persist while the stream keeps coming.
        for (int c = 0; c < 20; c++) begin
            send_byte(8'($urandom));
            chk("hold_err", 32'(Error),  32'd1);
            chk("hold_en",  32'(Enable), 32'd0);
        end
        chk("hold_writes", 32'(wr_cnt - base), 32'd2);

        // Illegal headers.
        base = wr_cnt;
        run_vectors(8, 9);
        repeat (2) idle_cycle(1'b0);
        chk("hdr_writes", 32'(wr_cnt - base), 32'd0);

        // Gapped stream: three idle cycles before every byte.
        apply_reset(1'b0);
        base = wr_cnt;
        good_stream(3);
        chk("gap_writes", 32'(wr_cnt - base), 32'd2);

        // Reset mid-word, with a byte offered during reset.
        apply_reset(1'b0);
        send_word(32'd2, 0);
        send_word(32'hE3A01005, 0);
        send_byte(8'h03);
        send_byte(8'h20);
        apply_reset(1'b1);
        check_reset_vals();
        good_stream(0);

        // Full-depth load.
        apply_reset(1'b0);
        base = wr_cnt;
        send_word(32'd64, 0);
        for (int i = 0; i < 64; i++) begin
            send_word(32'(i), 0);
            chk("n64_we",   32'(ImemWE), 32'd1);
            chk("n64_addr", ImemAddr, 32'(4 * i));
            chk("n64_wd",   ImemWD, 32'(i));
        end
        send_word(32'h0, 0);
        chk("n64_en",     32'(Enable), 32'd1);
        chk("n64_err",    32'(Error),  32'd0);
        chk("n64_writes", 32'(wr_cnt - base), 32'd64);
        chk("n64_laddr",  last_addr, 32'hFC);
        chk("n64_lwd",    last_wd, 32'h3F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
# boot_loader

Upstream program loader for the single-cycle ARM core. Receives a byte stream carrying a length header, program words and an XOR checksum trailer. Writes each word into instruction memory through a one-word write port. Once the checksum matches, asserts the core's run enable, replacing the hand-driven `enable` pulse used in simulation.

## Interface
- DEPTH, 64: instruction memory size in 32-bit words; the maximum legal word count.
- CLK  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high; sampled on the rising edge of CLK.
- RxData  in  8  incoming stream byte.
- RxValid  in  1  RxData is valid this cycle.
- RxReady  out  1  loader can accept a byte; a byte transfers when RxValid && RxReady at a rising edge.
- ImemWE  out  1  instruction memory write strobe; one cycle per word.
- ImemAddr  out  32  byte address of the write: 4 × word index.
- ImemWD  out  32  write data.
- Enable  out  1  core run enable; held high after a successful load until Reset.
- Error  out  1  load rejected; held until Reset.
- WordCount  out  32  latched header value N.

## Operation
- Stream format: header word N, then N data words, then one checksum word.
- Every word is 4 bytes, little-endian: first byte goes to bits 7:0, fourth byte to bits 31:24.
- Byte counter (0..3) advances only on a transfer and wraps after the fourth byte, completing a word.
- States:
  - HDR (reset state)
  - DATA
  - CHK
  - RUN
  - ERR
- HDR, word complete:
  - latch WordCount = word.
  - if word == 0 or word > DEPTH, go to ERR.
  - otherwise clear the word index and checksum, and go to DATA.
- DATA, word complete:
  - issue a write of the word at address 4 × index.
  - checksum ^= word; index += 1.
  - when index reaches N, go to CHK.
- CHK, word complete:
  - if word == checksum, go to RUN.
  - otherwise go to ERR.
- RUN: Enable = 1, RxReady = 0; the stream is ignored.
- ERR: Error = 1, Enable = 0, RxReady = 0; no further writes.
- RxReady = 1 in HDR, DATA and CHK. The loader never back-pressures mid-load: the write completes in one cycle and the next word needs at least 4 transfers.
- Partial words are held indefinitely; gaps in RxValid have no effect other than delay.
- Index width covers 0..DEPTH. Address arithmetic is zero-extended to 32 bits.

## Timing
- Reset values: RxReady = 1, ImemWE = 0, ImemAddr = 0, ImemWD = 0, Enable = 0, Error = 0, WordCount = 0, byte counter = 0, state = HDR.
- All outputs are registered.
- ImemWE is high for exactly the cycle after the edge that accepted a data word's fourth byte. ImemAddr and ImemWD are valid in that same cycle.
- The transition to RUN or ERR is registered on the edge that accepts the completing fourth byte; the first cycle after that edge is the first in the new state:
  - CHK, checksum match: Enable and RxReady = 0 are visible in that first cycle.
  - CHK, checksum mismatch: Error and RxReady = 0 are visible in that first cycle.
  - HDR, illegal count (0 or > DEPTH): same as a mismatch — Error and RxReady = 0 in that first cycle.
- Minimum load time for N words: 4 × (N + 2) transfer cycles, plus 1 cycle to Enable.
- Reset asserted in any state, including mid-word or mid-write: all of the above values apply on the next edge. Memory contents already written are not cleared. A new stream can start on the cycle after Reset deasserts.
- Reset takes priority over a simultaneous byte transfer; the byte is dropped.

## Test plan
- N = 2, data 0xE3A01005, 0xE2812003, checksum 0x01213006, contiguous bytes:
  - two ImemWE pulses: (addr 0x0, 0xE3A01005) and (addr 0x4, 0xE2812003).
  - Enable = 1 one cycle after the last byte; RxReady = 0; Error = 0.
- Same stream with checksum 0x01213007:
  - both writes occur.
  - Error = 1 and Enable = 0, remaining so for 20 cycles of further RxValid.
- Header N = 0, then N = 65 (Reset between):
  - Error = 1 after each header.
  - no ImemWE pulses.
  - WordCount = 0 and 65 respectively.
- N = 2 stream with RxValid deasserted for 3 random cycles between every byte:
  - identical writes and final Enable.
  - each ImemWE occurs exactly one cycle after its fourth byte.
- Reset for 1 cycle after the first data word plus 2 bytes:
  - all outputs return to reset values.
  - a full valid reload then succeeds with Enable = 1.
- N = 64, data word i = i, checksum = XOR of 0..63 (0x0):
  - 64 writes; last at address 0xFC with data 0x3F.
  - Enable = 1.
